lc3_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the LC3 core's instruction and data memory interface.
- The core issues fetch and data requests. This block serves them from internal IMEM/DMEM arrays after a configurable number of wait states, and pulses complete_instr / complete_data.
- Drops into the test top in place of the bench-driven memory. A preload port fills the arrays before a program runs.

---
 rtl/lc3_mem_pkg.sv | 13 +
 rtl/lc3_mem_channel.sv | 119 +++++++++++
 rtl/lc3_mem_responder.sv | 100 ++++++++++
 tb/tb_lc3_mem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and widths for the LC3 memory responder and its channels.
package lc3_mem_pkg;

    localparam int LAT_W  = 4;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_channel.sv
// One memory channel: request FSM, wait counter, request latches and a word array.
// Instantiated read-only for IMEM (WRITABLE = 0) and read/write for DMEM.
module lc3_mem_channel
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int LAT      = 0,
    parameter bit WRITABLE = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic [WORD_W-1:0] din,
    input  logic              pl_en,
    input  logic [ADDR_W-1:0] pl_addr,
    input  logic [WORD_W-1:0] pl_data,
    output logic [WORD_W-1:0] dout,
    output logic              complete,
    output logic              fire
);

    localparam int DEPTH = 1 << ADDR_W;

    mem_state_t        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              complete_q, complete_d;
    logic              fire_s;
    logic              store_s;

    // Array contents are deliberately outside the reset domain.
    logic [WORD_W-1:0] mem [DEPTH];

    // Next-state, latch capture and read-data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        din_d   = din_q;
        dout_d  = dout_q;
        fire_s  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    cnt_d   = LAT_W'(LAT);
                    rd_d    = rd;
                    din_d   = din;
                    state_d = MEM_WAIT;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                if (cnt_q != {LAT_W{1'b0}}) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else begin
                    fire_s  = 1'b1;
                    state_d = MEM_DONE;
                    if (rd_q) begin
                        dout_d = mem[addr_q];
                    end else begin
                        dout_d = dout_q;
                    end
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
        complete_d = (state_d == MEM_DONE);
        store_s    = fire_s && !rd_q && WRITABLE;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= {LAT_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            rd_q       <= 1'b0;
            din_q      <= {WORD_W{1'b0}};
            dout_q     <= {WORD_W{1'b0}};
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
            complete_q <= complete_d;
        end
    end

    // Preload is issued after the store so it takes priority on a shared word.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem[addr_q] <= din_q;
        end
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    assign dout     = dout_q;
    assign complete = complete_q;
    assign fire     = fire_s;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC3 core: IMEM and DMEM channels, preload
// demux and a count of completed fetches.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int IMEM_LAT = 0,
    parameter int DMEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       pc,
    input  logic              instrmem_rd,
    output logic [15:0]       Instr_dout,
    output logic              complete_instr,
    input  logic [15:0]       Data_addr,
    input  logic [15:0]       Data_din,
    input  logic              Data_rd,
    input  logic              data_req,
    output logic [15:0]       Data_dout,
    output logic              complete_data,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    output logic [15:0]       fetch_count
);

    logic        imem_pl_s;
    logic        dmem_pl_s;
    logic        imem_fire_s;
    logic        dmem_fire_unused_s;
    logic        addr_hi_unused_s;
    logic [15:0] fetch_count_q, fetch_count_d;

    assign imem_pl_s = load_en && !load_sel;
    assign dmem_pl_s = load_en && load_sel;

    // Upper address bits alias onto the array.
    assign addr_hi_unused_s = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};

    lc3_mem_channel #(
        .ADDR_W   (ADDR_W),
        .LAT      (IMEM_LAT),
        .WRITABLE (1'b0)
    ) u_imem (
        .clk      (clock),
        .rst_n    (reset),
        .req      (instrmem_rd),
        .addr     (pc[ADDR_W-1:0]),
        .rd       (1'b1),
        .din      (16'h0000),
        .pl_en    (imem_pl_s),
        .pl_addr  (load_addr),
        .pl_data  (load_data),
        .dout     (Instr_dout),
        .complete (complete_instr),
        .fire     (imem_fire_s)
    );

    lc3_mem_channel #(
        .ADDR_W   (ADDR_W),
        .LAT      (DMEM_LAT),
        .WRITABLE (1'b1)
    ) u_dmem (
        .clk      (clock),
        .rst_n    (reset),
        .req      (data_req),
        .addr     (Data_addr[ADDR_W-1:0]),
        .rd       (Data_rd),
        .din      (Data_din),
        .pl_en    (dmem_pl_s),
        .pl_addr  (load_addr),
        .pl_data  (load_data),
        .dout     (Data_dout),
        .complete (complete_data),
        .fire     (dmem_fire_unused_s)
    );

    // Count advances on the edge that enters DONE, wrapping naturally.
    always_comb begin
        if (imem_fire_s) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Fetch counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder against a word-array reference model.
module tb_lc3_mem_responder;

    localparam int AW   = 8;
    localparam int ILAT = 0;
    localparam int DLAT = 3;
    localparam int NK   = ((ILAT > DLAT) ? ILAT : DLAT) + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   pc = 16'h0000;
    logic          instrmem_rd = 1'b0;
    logic [15:0]   Instr_dout;
    logic          complete_instr;
    logic [15:0]   Data_addr = 16'h0000;
    logic [15:0]   Data_din = 16'h0000;
    logic          Data_rd = 1'b0;
    logic          data_req = 1'b0;
    logic [15:0]   Data_dout;
    logic          complete_data;
    logic          load_en = 1'b0;
    logic          load_sel = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [15:0]   load_data = 16'h0000;
    logic [15:0]   fetch_count;

    lc3_mem_responder #(.ADDR_W(AW), .IMEM_LAT(ILAT), .DMEM_LAT(DLAT)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
        .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd),
        .data_req(data_req), .Data_dout(Data_dout), .complete_data(complete_data),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
        .load_data(load_data), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [15:0] imem_m [256];
    logic [15:0] dmem_m [256];
    logic [15:0] last_i = 16'h0000;
    logic [15:0] last_d = 16'h0000;
    logic [15:0] fcount = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input bit sel, input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
        if (sel) dmem_m[a] = d; else imem_m[a] = d;
    endtask

    // One fetch and/or one data access issued on the same edge; every cycle is checked.
    task automatic access(input bit di, input logic [15:0] ia,
                          input bit dd, input bit drd, input logic [15:0] da,
                          input logic [15:0] dv, input bit coll, input logic [15:0] cv);
        logic [15:0] new_i, new_d;
        logic [7:0]  ix, dx;
        ix = ia[7:0];
        dx = da[7:0];
        new_i = imem_m[ix];
        new_d = drd ? dmem_m[dx] : last_d;
        @(negedge clock);
        pc = ia; instrmem_rd = di; Data_addr = da; Data_rd = drd; Data_din = dv; data_req = dd;
        for (int k = 0; k <= NK; k++) begin
            @(negedge clock);
            chk("complete_instr", 32'(complete_instr), 32'(di && k == ILAT + 1));
            chk("complete_data", 32'(complete_data), 32'(dd && k == DLAT + 1));
            chk("Instr_dout", 32'(Instr_dout), 32'((di && k >= ILAT + 1) ? new_i : last_i));
            chk("Data_dout", 32'(Data_dout), 32'((dd && k >= DLAT + 1) ? new_d : last_d));
            chk("fetch_count", 32'(fetch_count),
                32'(16'(fcount + ((di && k >= ILAT + 1) ? 16'd1 : 16'd0))));
            if (k == 0) begin
                instrmem_rd = 1'b0; data_req = 1'b0;
                pc = 16'($urandom); Data_addr = 16'($urandom);
                Data_din = 16'($urandom); Data_rd = 1'($urandom);
            end
            if (dd && coll && k == DLAT) begin
                load_en = 1'b1; load_sel = 1'b1; load_addr = dx; load_data = cv;
            end else begin
                load_en = 1'b0;
            end
        end
        if (di) begin
            last_i = new_i;
            fcount = fcount + 16'd1;
        end
        if (dd) begin
            if (drd) last_d = new_d; else dmem_m[dx] = dv;
            if (coll) dmem_m[dx] = cv;
        end
    endtask

    initial begin
        // Fill both arrays while in reset so every word has a known value.
        for (int a = 0; a < 256; a++) begin
            preload(1'b0, 8'(a), 16'($urandom));
            preload(1'b1, 8'(a), 16'($urandom));
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            pc = 16'($urandom); instrmem_rd = 1'($urandom); data_req = 1'($urandom);
            Data_addr = 16'($urandom); Data_din = 16'($urandom); Data_rd = 1'($urandom);
            @(negedge clock);
            chk("rst Instr_dout", 32'(Instr_dout), 32'h0);
            chk("rst Data_dout", 32'(Data_dout), 32'h0);
            chk("rst complete_instr", 32'(complete_instr), 32'h0);
            chk("rst complete_data", 32'(complete_data), 32'h0);
            chk("rst fetch_count", 32'(fetch_count), 32'h0);
        end
        instrmem_rd = 1'b0; data_req = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk("idle complete_instr", 32'(complete_instr), 32'h0);
            chk("idle complete_data", 32'(complete_data), 32'h0);
        end

        // Basic fetch pair.
        preload(1'b0, 8'd5, 16'h1234);
        preload(1'b0, 8'd6, 16'h5678);
        access(1'b1, 16'h0005, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        access(1'b1, 16'h0006, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        chk("fetch_count two", 32'(fetch_count), 32'd2);

        // Store via aliased address, then load it back.
        access(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0103, 16'hBEEF, 1'b0, 16'h0000);
        access(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0, 16'h0000);
        chk("alias load", 32'(Data_dout), 32'h0000BEEF);

        // Concurrent fetch and load.
        access(1'b1, 16'h0006, 1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0, 16'h0000);

        // Preload colliding with a store, then with a load.
        access(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h1111, 1'b1, 16'h2222);
        access(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'h3333);
        access(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0000);

        // Reset in the middle of a store aborts it.
        preload(1'b1, 8'h40, 16'hA5A5);
        @(negedge clock);
        Data_addr = 16'h0040; Data_din = 16'h1111; Data_rd = 1'b0; data_req = 1'b1;
        @(negedge clock);
        data_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort Data_dout", 32'(Data_dout), 32'h0);
        chk("abort Instr_dout", 32'(Instr_dout), 32'h0);
        chk("abort fetch_count", 32'(fetch_count), 32'h0);
        chk("abort complete_data", 32'(complete_data), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        last_i = 16'h0000; last_d = 16'h0000; fcount = 16'h0000;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            chk("abort no pulse", 32'(complete_data), 32'h0);
        end
        access(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0040, 16'h0000, 1'b0, 16'h0000);
        chk("abort word kept", 32'(Data_dout), 32'h0000A5A5);

        // Randomized traffic over a small aliased window.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0)
                preload(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom));
            access(1'($urandom), {8'($urandom), 8'($urandom_range(0, 15))},
                   1'($urandom), 1'($urandom), {8'($urandom), 8'($urandom_range(0, 15))},
                   16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
